// File: rtl/fir_pkg.sv
// Shared FIR datapath definitions: sample format and default decimation factor.
package fir_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned DECIM_LOG2 = 2;

  // Signed 1.1.14 sample as produced by the FIR lowpass.
  typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO, power-of-two depth, async active-high reset.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o    = level_q;

endmodule

// File: rtl/fir_decimator.sv
// Decimates the FIR output by 2**DECIM_LOG2 into a FWFT output FIFO with sticky overflow.
// Define FIR_DECIM_AVG_EN to output the mean of each group instead of its last sample.
module fir_decimator #(
  parameter int unsigned DATA_W     = fir_pkg::DATA_W,
  parameter int unsigned DECIM_LOG2 = fir_pkg::DECIM_LOG2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          In_Valid,
  input  logic signed [DATA_W-1:0]      In_Data,
  output logic                          Out_Valid,
  input  logic                          Out_Ready,
  output logic signed [DATA_W-1:0]      Out_Data,
  output logic                          Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level
);

  logic [DECIM_LOG2-1:0]     phase_q;
  logic                      last_phase;
  logic                      dec_valid;
  logic signed [DATA_W-1:0]  dec_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      drop;
  logic                      overflow_q;

  // All-ones phase is DECIM-1; the counter wraps to 0 on its own.
  assign last_phase = (phase_q == '1);
  assign dec_valid  = In_Valid && last_phase;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase_q <= '0;
    end else if (In_Valid) begin
      phase_q <= phase_q + DECIM_LOG2'(1);
    end
  end

`ifdef FIR_DECIM_AVG_EN
  localparam int unsigned ACC_W = DATA_W + DECIM_LOG2;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_sum;

  // Phase 0 starts a fresh group, so the stale accumulator is ignored there.
  assign acc_sum  = ((phase_q == '0) ? '0 : acc_q)
                  + {{DECIM_LOG2{In_Data[DATA_W-1]}}, In_Data};
  assign dec_data = acc_sum[ACC_W-1:DECIM_LOG2];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q <= '0;
    end else if (In_Valid) begin
      acc_q <= acc_sum;
    end
  end
`else
  assign dec_data = In_Data;
`endif

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (dec_valid),
    .push_data_i (dec_data),
    .pop_i       (Out_Ready),
    .pop_data_o  (Out_Data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (Fifo_Level)
  );

  assign Out_Valid = !fifo_empty;
  assign drop      = dec_valid && fifo_full && !(Out_Valid && Out_Ready);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign Overflow = overflow_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Scoreboard bench for fir_decimator (DECIM=4, FIFO depth 4); honours FIR_DECIM_AVG_EN.
module tb_fir_decimator;
  import fir_pkg::*;

  logic                CLK = 1'b0;
  logic                RST;
  logic                In_Valid;
  logic signed [15:0]  In_Data;
  logic                Out_Valid;
  logic                Out_Ready;
  logic signed [15:0]  Out_Data;
  logic                Overflow;
  logic [2:0]          Fifo_Level;

  int      total = 0;
  int      bad   = 0;
  sample_t exp_q[$];

  fir_decimator #(
    .DATA_W     (16),
    .DECIM_LOG2 (2),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .In_Valid   (In_Valid),
    .In_Data    (In_Data),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Out_Data   (Out_Data),
    .Overflow   (Overflow),
    .Fifo_Level (Fifo_Level)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic sample_t grp_exp(input int a, input int b, input int c, input int d);
    int s;
`ifdef FIR_DECIM_AVG_EN
    s = (a + b + c + d) >>> 2;
`else
    s = d + 0 * (a + b + c);
`endif
    return sample_t'(s);
  endfunction

  // One clock: inputs applied now, captured by the next rising edge, return #1 after it.
  task automatic cyc(input logic v, input int d, input logic rdy);
    In_Valid  = v;
    In_Data   = 16'(d);
    Out_Ready = rdy;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_group(input int a, input int b, input int c, input int d,
                            input logic rdy, input logic rdy_last, input logic keep);
    cyc(1'b1, a, rdy);
    cyc(1'b1, b, rdy);
    cyc(1'b1, c, rdy);
    if (keep) exp_q.push_back(grp_exp(a, b, c, d));
    cyc(1'b1, d, rdy_last);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    In_Valid = 1'b0;
    In_Data = '0;
    Out_Ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Monitor: every accepted transfer must match the scoreboard head.
  always @(negedge CLK) begin
    if (!RST && Out_Valid && Out_Ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", int'(Out_Data), -99999);
      end else begin
        check("out_data", int'(Out_Data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sample_t hand[2];
    RST = 1'b1;
    In_Valid = 1'b0;
    In_Data = '0;
    Out_Ready = 1'b0;
    #2;
    check("rst_out_valid", int'(Out_Valid), 0);
    check("rst_level", int'(Fifo_Level), 0);
    check("rst_overflow", int'(Overflow), 0);
    check("rst_out_data", int'(Out_Data), 0);
    do_reset();

    // Inputs 1..8 streaming, downstream always ready.
`ifdef FIR_DECIM_AVG_EN
    hand[0] = 16'sd2;
    hand[1] = 16'sd6;
`else
    hand[0] = 16'sd4;
    hand[1] = 16'sd8;
`endif
    for (int i = 1; i <= 8; i++) begin
      if (i % 4 == 0) exp_q.push_back(hand[i/4-1]);
      cyc(1'b1, i, 1'b1);
      if (i == 3) check("no_early_valid", int'(Out_Valid), 0);
      if (i % 4 == 0) check("latency1_valid", int'(Out_Valid), 1);
    end
    cyc(1'b0, 0, 1'b1);
    check("stream_level", int'(Fifo_Level), 0);
    check("stream_overflow", int'(Overflow), 0);

    // Valid toggling: idle cycles carry junk data and must not advance phase.
    for (int k = 0; k < 8; k++) begin
      if (k == 6) exp_q.push_back(grp_exp(10, 20, 30, 40));
      cyc((k % 2) == 0, ((k % 2) == 0) ? 10 * (k / 2 + 1) : 32767, 1'b1);
      if (k == 5) check("toggle_no_early", int'(Out_Valid), 0);
      if (k == 6) check("toggle_valid", int'(Out_Valid), 1);
    end
    send_group(-1, -1, -1, -2, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 0, 1'b1);
    check("neg_drained", int'(Fifo_Level), 0);

    // Fill with no ready, fifth sample dropped, then drain.
    for (int g = 0; g < 4; g++) send_group(10*g+1, 10*g+2, 10*g+3, 10*g+5, 1'b0, 1'b0, 1'b1);
    check("full_level", int'(Fifo_Level), 4);
    check("full_no_overflow", int'(Overflow), 0);
    check("full_head", int'(Out_Data), int'(exp_q[0]));
    send_group(91, 92, 93, 95, 1'b0, 1'b0, 1'b0);
    check("drop_level", int'(Fifo_Level), 4);
    check("drop_overflow", int'(Overflow), 1);
    repeat (4) cyc(1'b0, 0, 1'b1);
    check("drain_level", int'(Fifo_Level), 0);
    check("overflow_sticky", int'(Overflow), 1);
    check("drain_valid", int'(Out_Valid), 0);

    // Full with simultaneous pop and push.
    do_reset();
    check("reset_clears_overflow", int'(Overflow), 0);
    for (int g = 0; g < 4; g++) send_group(-3*g, 7, -7, 100+g, 1'b0, 1'b0, 1'b1);
    send_group(1, 1, 1, 200, 1'b0, 1'b1, 1'b1);
    check("pushpop_level", int'(Fifo_Level), 4);
    check("pushpop_overflow", int'(Overflow), 0);
    repeat (4) cyc(1'b0, 0, 1'b1);
    check("pushpop_drained", int'(Fifo_Level), 0);

    // Mid-group reset with samples queued.
    send_group(5, 6, 7, 8, 1'b0, 1'b0, 1'b0);
    send_group(9, 10, 11, 12, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 13, 1'b0);
    cyc(1'b1, 14, 1'b0);
    check("pre_rst_level", int'(Fifo_Level), 2);
    RST = 1'b1;
    #2;
    check("midrst_valid", int'(Out_Valid), 0);
    check("midrst_level", int'(Fifo_Level), 0);
    check("midrst_data", int'(Out_Data), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    cyc(1'b1, 1, 1'b1);
    cyc(1'b1, 2, 1'b1);
    check("phase_restart", int'(Out_Valid), 0);
    cyc(1'b1, 3, 1'b1);
    exp_q.push_back(grp_exp(1, 2, 3, 44));
    cyc(1'b1, 44, 1'b1);
    check("restart_valid", int'(Out_Valid), 1);
    cyc(1'b0, 0, 1'b1);
    cyc(1'b0, 0, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_decimator.md
FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width (signed 1.1.14).
REQ-002 SHALL have parameter DECIM_LOG2, default 2, decimation factor DECIM = 2**DECIM_LOG2 (legal 1..4).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of 2, >=2).
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port In_Valid  input  1  In_Data qualifier; there is no backpressure to the FIR.
REQ-007 SHALL have port In_Data  input  DATA_W  signed filtered sample from the FIR lowpass output.
REQ-008 SHALL have port Out_Valid  output  1  high when the FIFO is non-empty.
REQ-009 SHALL have port Out_Ready  input  1  downstream accept; a transfer occurs when Out_Valid && Out_Ready.
REQ-010 SHALL have port Out_Data  output  DATA_W  signed decimated sample at the FIFO head.
REQ-011 SHALL have port Overflow  output  1  sticky flag: a decimated sample was dropped.
REQ-012 SHALL have port Fifo_Level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 SHALL keep a phase counter 0..DECIM-1 that advances only on In_Valid and wraps from DECIM-1 to 0.
REQ-014 SHALL produce one decimated sample on each In_Valid cycle where the phase counter equals DECIM-1.
REQ-015 SHALL, without the averaging feature, take the decimated sample as In_Data of that last-phase cycle.
REQ-016 SHALL push the decimated sample into the FIFO in the same edge, so Out_Valid/Out_Data reflect it one cycle after the last contributing input (latency 1 when the FIFO was empty).
REQ-017 SHALL present the FIFO head combinationally on Out_Data (first-word fall-through), stable while Out_Valid && !Out_Ready.
REQ-018 SHALL pop the head on Out_Valid && Out_Ready; Out_Data is don't-care while Out_Valid is low.
REQ-019 SHALL, on a push when full with no simultaneous pop, drop the new sample, keep FIFO contents unchanged, and set Overflow.
REQ-020 SHALL, on a push and pop in the same cycle when full, accept both; Fifo_Level stays FIFO_DEPTH and Overflow is unchanged.
REQ-021 SHALL, on a push and pop in the same cycle when empty, not bypass; the pop is not possible (Out_Valid low) and the push lands normally.
REQ-022 SHALL hold Overflow high until RST; no other clear exists.
REQ-023 SHALL leave the phase counter unchanged on cycles with In_Valid low.

Reset
REQ-024 SHALL, while RST is high, immediately force phase counter=0, accumulator=0, FIFO empty, Out_Valid=0, Out_Data=0, Overflow=0, Fifo_Level=0.
REQ-025 SHALL discard any partial decimation group and all queued samples when RST asserts mid-operation; the first In_Valid after release is phase 0.

Configuration
REQ-026 SHALL support macro FIR_DECIM_AVG_EN; when defined, the decimated sample is the mean of the DECIM inputs of the group.
REQ-027 SHALL, with FIR_DECIM_AVG_EN, accumulate in a DATA_W+DECIM_LOG2-bit signed register cleared at phase 0, and output (acc + In_Data) arithmetically shifted right by DECIM_LOG2 (truncate toward minus infinity, no overflow possible).
REQ-028 SHALL, without FIR_DECIM_AVG_EN, contain no accumulator logic, per REQ-015.

Structure
REQ-029 SHALL take DATA_W, the signed sample typedef and the default DECIM_LOG2 from shared package fir_pkg, which the FIR filter also uses.
REQ-030 SHALL implement the FIFO as sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level), with the decimation and averaging logic in fir_decimator.

Verification
REQ-031 Reset then In_Valid=1 continuously with In_Data=1,2,3,...,8, Out_Ready=1, no macro -> Out_Data 4 then 8, each one cycle after its input; Overflow=0.
REQ-032 Same stimulus with FIR_DECIM_AVG_EN -> Out_Data 2 (10>>2) then 6 (26>>2); for inputs -1,-1,-1,-2 -> Out_Data -2.
REQ-033 Out_Ready=0, In_Valid=1 for 5*DECIM cycles (DEPTH 4) -> Fifo_Level reaches 4, fifth sample dropped, Overflow=1 and stays 1; then Out_Ready=1 -> the first four samples drain in order.
REQ-034 FIFO full and Out_Ready=1 in the same cycle a decimated sample is produced -> both pop and push occur, Fifo_Level stays 4, Overflow remains 0.
REQ-035 In_Valid toggling 1/0 every cycle -> one output per DECIM valid inputs; idle cycles do not advance phase.
REQ-036 RST pulsed after 2 of 4 inputs of a group with 2 samples queued -> Out_Valid=0 and Fifo_Level=0 immediately; the next group restarts at phase 0.
